fbr_resolve: RTL and testbench
==============================

Name: fbr_resolve

Overview:
- Consumes the registered 32-bit compare result (0 or 1) produced by the FPU less-than stage and resolves floating-point conditional branches.
- Issue logic presents compare operands to the comparator and, in the same cycle, a branch request to this block.
- The block tracks in-flight requests across the comparator's fixed latency, pairs each with its result, computes taken/target, and buffers resolved branches in a small FIFO drained by a valid/ready handshake toward the fetch redirect logic.

Parameters:
- CMP_LAT, 1, comparator latency in cycles from operand issue to valid y (1..4).
- FIFO_DEPTH, 4, resolved-branch buffer entries; power of two, 2..8.
- TAG_W, 5, width of the branch tag.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset; synchronous, active-high (asserted when 1).
- req_valid  in  1  branch request issued this cycle; comparator operands are presented in the same cycle.
- req_ready  out  1  block can accept a request this cycle.
- req_neg  in  1  0: branch if y[0]==1; 1: branch if y[0]==0.
- req_target  in  32  branch target PC.
- req_pc_next  in  32  fall-through PC.
- req_tag  in  TAG_W  branch identifier.
- cmp_y  in  32  comparator output; only bit 0 is used.
- flush  in  1  discard all in-flight and buffered requests.
- out_valid  out  1  resolved branch available at FIFO head.
- out_ready  in  1  consumer accepts the head entry.
- out_taken  out  1  branch taken.
- out_pc  out  32  out_taken ? target : pc_next.
- out_tag  out  TAG_W  tag of the head entry.

Behaviour:
- Acceptance: a request is accepted when req_valid && req_ready. Issue logic must not present operands for an unaccepted request.
- Credit rule: req_ready = (inflight + fifo_count) < FIFO_DEPTH, computed from registered state only. There is no combinational path from out_ready to req_ready. This guarantees a FIFO slot for every in-flight result, because the comparator cannot stall.
- Tracking pipeline: CMP_LAT stages, each holding {v, neg, target, pc_next, tag}. An accepted request enters stage 0 at the next posedge and shifts one stage per cycle unconditionally.
- Result pairing: when the last stage has v=1, cmp_y is valid in that cycle. The block computes taken = cmp_y[0] ^ neg and pc = taken ? target : pc_next, and writes {taken, pc, tag} to the FIFO at that posedge. cmp_y[31:1] is ignored.
- Inflight count: number of valid pipeline stages, 0..CMP_LAT.
- Latency: request accepted at edge N produces out_valid at edge N+CMP_LAT+1 when the FIFO was empty. With CMP_LAT=1, out_valid is high 2 cycles after acceptance.
- FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits; wraps modulo depth.
  - out_valid = count != 0; out_* are driven from the head entry.
  - A pop occurs on out_valid && out_ready.
  - A simultaneous push and pop in one cycle leaves count unchanged. On an empty FIFO with a simultaneous push, no bypass: the pushed entry appears on the next cycle.
  - Overflow cannot occur under the credit rule. The FIFO is full only when inflight = 0. Verification asserts count <= FIFO_DEPTH at all times.
- Output hold: while out_valid && !out_ready, out_taken, out_pc and out_tag hold stable.
- Flush: at the posedge where flush=1:
  - all pipeline v bits clear and FIFO pointers reset;
  - a request accepted in that same cycle is discarded;
  - a result arriving in that same cycle is dropped.
  - req_ready may be high during flush; flush wins.
- Reset (rstn=1 at posedge):
  - all v bits and pointers clear;
  - out_valid=0, out_taken=0, out_pc=0, out_tag=0, req_ready=0.
  - req_ready rises the cycle after rstn deasserts.
  - Reset mid-operation drops everything, same as flush.
- Reset/flush precedence: reset overrides flush.
- Data outputs: out_taken/out_pc/out_tag read 0 whenever count==0.
- No combinational path from cmp_y to any output.

Test Plan:
- CMP_LAT=1, single request (neg=0, target=0x1000, pc_next=0x0204, tag=3), cmp_y=1 one cycle later, out_ready=1 -> out_valid high exactly 2 cycles after acceptance with taken=1, pc=0x1000, tag=3; out_valid low the next cycle.
- Same request with neg=1 and cmp_y=1 -> taken=0, pc=0x0204. Repeat with cmp_y=0x00000000 -> taken=1, pc=0x1000. Repeat with cmp_y=0xFFFFFFFE -> treated as 0.
- Back-to-back requests every cycle with tags 0..7, out_ready=0 -> req_ready falls after 4 accepts; 4 entries buffered in order. Then out_ready=1 -> entries drain tags 0,1,2,3 in order, req_ready recovers, and accepting resumes with no lost or duplicated tags.
- Concurrent push/pop: steady stream with out_ready=1 -> count stays constant, throughput of 1 branch/cycle, pointers wrap past FIFO_DEPTH with no corruption over 20 requests.
- Flush with 1 in-flight plus 2 buffered, plus a request accepted in the flush cycle -> next cycle out_valid=0 and inflight=0; the next new request resolves normally with its own tag.
- rstn asserted for 1 cycle mid-stream -> all outputs 0 and req_ready=0 during reset; req_ready=1 the cycle after release; no stale out_valid appears afterward.

Source files
------------

// File: rtl/fbr_resolve_if.sv
// Bundle of the issue-side request, comparator result, flush and the
// fetch-redirect output handshake for the FP branch resolver.
//
// Handshake rules (both channels): a transfer happens on a posedge where
// valid && ready are both 1. Payload must be stable while valid is high.
// req_ready depends on registered state only. out_* hold stable while
// out_valid && !out_ready.
interface fbr_resolve_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_neg;
  logic [31:0]      req_target;
  logic [31:0]      req_pc_next;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      cmp_y;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [31:0]      out_pc;
  logic [TAG_W-1:0] out_tag;

  // Issue logic, comparator and fetch redirect side
  modport master (
    output req_valid, req_neg, req_target, req_pc_next, req_tag,
    output cmp_y, flush, out_ready,
    input  req_ready, out_valid, out_taken, out_pc, out_tag
  );

  // Branch resolver side
  modport slave (
    input  req_valid, req_neg, req_target, req_pc_next, req_tag,
    input  cmp_y, flush, out_ready,
    output req_ready, out_valid, out_taken, out_pc, out_tag
  );
endinterface

// File: rtl/fbr_resolve.sv
// Floating-point conditional branch resolver: tracks requests across the
// fixed comparator latency, pairs each with its compare result, and buffers
// resolved {taken, pc, tag} entries in a FIFO for the fetch redirect logic.
// A credit rule (in-flight + buffered < depth) guarantees a FIFO slot for
// every result, since the comparator cannot be stalled.
module fbr_resolve #(
  parameter int CMP_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic       clk,
  input  logic       rstn,
  fbr_resolve_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(FIFO_DEPTH + CMP_LAT + 1);
  localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);

  typedef struct packed {
    logic             v;
    logic             neg;
    logic [31:0]      target;
    logic [31:0]      pc_next;
    logic [TAG_W-1:0] tag;
  } stage_t;

  typedef struct packed {
    logic             taken;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  stage_t        pipe_q [CMP_LAT];
  entry_t        mem_q  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] count;
  logic          live_q;
  logic [OW-1:0] inflight;
  logic [OW-1:0] occupancy;
  logic          accept;
  logic          push;
  logic          pop;
  logic          res_taken;
  stage_t        last;
  entry_t        head;
  logic          cmp_y_unused;

  // Only bit 0 of the comparator result carries the less-than outcome
  assign cmp_y_unused = ^bus.cmp_y[31:1];

  // Count valid pipeline stages (requests waiting for their compare result)
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CMP_LAT; i++) begin
      inflight = inflight + OW'(pipe_q[i].v);
    end
  end

  assign count     = wr_ptr_q - rd_ptr_q;
  assign occupancy = inflight + OW'(count);
  assign last      = pipe_q[CMP_LAT-1];
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.req_ready = live_q && (occupancy < DEPTH_O);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = last.v;
  assign pop           = bus.out_valid && bus.out_ready;
  assign res_taken     = bus.cmp_y[0] ^ last.neg;

  // Head entry drives the outputs; everything reads zero while empty
  assign bus.out_valid = (count != '0);
  assign bus.out_taken = bus.out_valid && head.taken;
  assign bus.out_pc    = bus.out_valid ? head.pc  : '0;
  assign bus.out_tag   = bus.out_valid ? head.tag : '0;

  // Hold req_ready low through reset and release it one cycle after
  always_ff @(posedge clk) begin
    live_q <= !rstn;
  end

  // Tracking pipeline: shifts every cycle; reset/flush invalidate all stages
  always_ff @(posedge clk) begin
    pipe_q[0] <= {accept && !bus.flush, bus.req_neg, bus.req_target,
                  bus.req_pc_next, bus.req_tag};
    for (int i = 1; i < CMP_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
    if (rstn || bus.flush) begin
      for (int i = 0; i < CMP_LAT; i++) begin
        pipe_q[i].v <= 1'b0;
      end
    end
  end

  // Resolved-branch FIFO: push paired result, pop on handshake, no bypass
  always_ff @(posedge clk) begin
    if (rstn || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {res_taken,
                                    res_taken ? last.target : last.pc_next,
                                    last.tag};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fbr_resolve.sv
// Self-checking bench for fbr_resolve: directed scenarios followed by a
// randomized run, all checked every cycle against a queue-based model.
module tb_fbr_resolve;
  localparam int CMP_LAT    = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 5;
  localparam int EW         = 1 + 32 + TAG_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fbr_resolve_if #(.TAG_W(TAG_W)) bus ();

  fbr_resolve #(
    .CMP_LAT   (CMP_LAT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk (clk),
    .rstn(rst),
    .bus (bus)
  );

  // Reference model: requests waiting for their compare result, and the
  // resolved entries visible to the consumer, in order.
  typedef struct {
    int               due;
    logic             neg;
    logic [31:0]      target;
    logic [31:0]      pc_next;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
  } pend_t;

  pend_t          pend_q[$];
  logic [EW-1:0]  exp_q[$];
  logic           live = 1'b0;
  int             cyc = 0;
  int             n_tests = 0;
  int             n_fail = 0;
  logic [31:0]    req_y = '0;
  bit             accepted;

  // Scoreboard compare
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] head;
    logic          ready_m;
    head    = (exp_q.size() != 0) ? exp_q[0] : '0;
    ready_m = live && ((pend_q.size() + exp_q.size()) < FIFO_DEPTH);
    check("req_ready", bus.req_ready, ready_m);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("out_taken", bus.out_taken, head[EW-1]);
    check("out_pc",    bus.out_pc,    head[TAG_W +: 32]);
    check("out_tag",   bus.out_tag,   head[TAG_W-1:0]);
  endtask

  // One clock: drive comparator result, advance model at posedge,
  // then compare every output at the following negedge.
  task automatic tick();
    bit ready_m;
    bit due;
    pend_t p;
    bit tk;
    ready_m = live && ((pend_q.size() + exp_q.size()) < FIFO_DEPTH);
    due     = (pend_q.size() != 0) && (pend_q[0].due == cyc);
    bus.cmp_y = due ? pend_q[0].y : $urandom;
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      live = 1'b0;
    end else if (bus.flush) begin
      pend_q.delete();
      exp_q.delete();
      live = 1'b1;
    end else begin
      if (bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (due) begin
        p  = pend_q.pop_front();
        tk = p.y[0] ^ p.neg;
        exp_q.push_back({tk, tk ? p.target : p.pc_next, p.tag});
      end
      if (bus.req_valid && ready_m) begin
        pend_q.push_back('{due: cyc + CMP_LAT, neg: bus.req_neg,
                           target: bus.req_target, pc_next: bus.req_pc_next,
                           tag: bus.req_tag, y: req_y});
        accepted = 1'b1;
      end
      live = 1'b1;
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  // Driver tasks
  task automatic drive_req(input bit v, input bit neg, input logic [31:0] tgt,
                           input logic [31:0] pcn, input logic [TAG_W-1:0] tag,
                           input logic [31:0] y);
    bus.req_valid   = v;
    bus.req_neg     = neg;
    bus.req_target  = tgt;
    bus.req_pc_next = pcn;
    bus.req_tag     = tag;
    req_y           = y;
  endtask

  task automatic drive_idle();
    drive_req(1'b0, $urandom_range(0, 1), $urandom, $urandom, TAG_W'($urandom), $urandom);
  endtask

  task automatic run_single(input bit neg, input logic [31:0] y,
                            input bit exp_taken, input logic [31:0] exp_pc);
    bus.out_ready = 1'b1;
    drive_req(1'b1, neg, 32'h0000_1000, 32'h0000_0204, 5'd3, y);
    tick();
    check("single_early_valid", bus.out_valid, 0);
    drive_idle();
    tick();
    check("single_valid", bus.out_valid, 1);
    check("single_taken", bus.out_taken, exp_taken);
    check("single_pc",    bus.out_pc,    exp_pc);
    check("single_tag",   bus.out_tag,   3);
    tick();
    check("single_after", bus.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int next_tag;
    int acc_dut;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.cmp_y     = '0;
    drive_idle();

    // Reset
    rst = 1'b1;
    tick();
    tick();
    check("reset_ready", bus.req_ready, 0);
    check("reset_valid", bus.out_valid, 0);
    rst = 1'b0;
    tick();
    check("release_ready", bus.req_ready, 1);

    // Single branches: polarity and upper compare bits ignored
    run_single(1'b0, 32'h0000_0001, 1'b1, 32'h0000_1000);
    run_single(1'b1, 32'h0000_0001, 1'b0, 32'h0000_0204);
    run_single(1'b1, 32'h0000_0000, 1'b1, 32'h0000_1000);
    run_single(1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0000_1000);

    // Back-pressure: fill with tags, then drain in order
    bus.out_ready = 1'b0;
    next_tag = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b1, $urandom_range(0, 1), $urandom, $urandom, TAG_W'(next_tag), $urandom);
      tick();
      if (accepted) next_tag++;
      if (i == 3) begin
        check("bp_full_ready", bus.req_ready, 0);
        check("bp_head_tag",   bus.out_tag,   0);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && next_tag < 8; i++) begin
      drive_req(1'b1, $urandom_range(0, 1), $urandom, $urandom, TAG_W'(next_tag), $urandom);
      tick();
      if (accepted) next_tag++;
    end
    drive_idle();
    for (int i = 0; i < 6; i++) tick();

    // Steady stream: one branch per cycle, pointers wrap
    acc_dut = 0;
    for (int i = 0; i < 20; i++) begin
      acc_dut += int'(bus.req_ready);
      drive_req(1'b1, $urandom_range(0, 1), $urandom, $urandom, TAG_W'(i + 8), $urandom);
      tick();
    end
    check("stream_accepts", acc_dut, 20);
    drive_idle();
    for (int i = 0; i < 4; i++) tick();

    // Flush with 2 buffered, 1 in flight and 1 accepted in the flush cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 1'b0, $urandom, $urandom, TAG_W'(10 + i), $urandom);
      tick();
    end
    drive_req(1'b1, 1'b0, $urandom, $urandom, 5'd13, $urandom);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", bus.out_valid, 0);
    check("flush_ready", bus.req_ready, 1);
    bus.out_ready = 1'b1;
    drive_req(1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, 5'd14, 32'h1);
    tick();
    drive_idle();
    tick();
    check("flush_next_valid", bus.out_valid, 1);
    check("flush_next_tag",   bus.out_tag,   14);
    check("flush_next_pc",    bus.out_pc,    32'h0000_2000);
    tick();

    // Reset mid-stream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, $urandom_range(0, 1), $urandom, $urandom, TAG_W'(i), $urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_ready", bus.req_ready, 0);
    check("midrst_pc",    bus.out_pc,    0);
    check("midrst_tag",   bus.out_tag,   0);
    rst = 1'b0;
    drive_idle();
    tick();
    check("midrst_release_ready", bus.req_ready, 1);
    check("midrst_release_valid", bus.out_valid, 0);
    tick();
    check("midrst_no_stale", bus.out_valid, 0);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      drive_req($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
                TAG_W'($urandom), $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 49) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive_idle();
    for (int i = 0; i < 8; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
